// File: rtl/onehot_encoder.sv
// Purpose : registered one-hot to binary encoder (LSB priority) with error flag and saturating error count.
// Latency : 2 cycles; a word accepted at edge k is presented after edge k+1 if S2 is free.
// Backpr. : absorbs at most 2 words while out_ready is low; in_ready = !s1_v || !s2_v || out_ready.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_lines carries the 2^N line word
//   out_valid/out_ready  output handshake; out_code/out_err carry the result
//   err_cnt              count of error results handed to the consumer, saturating
module onehot_encoder #(
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [(1<<N)-1:0]   in_lines,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_code,
    output logic                out_err,
    output logic [CNT_W-1:0]    err_cnt
);
    localparam int W = 1 << N;

    // Stage 1: raw line word
    logic               s1_v_q,     s1_v_d;
    logic [W-1:0]       s1_lines_q, s1_lines_d;
    // Stage 2: encoded result
    logic               s2_v_q,     s2_v_d;
    logic [N-1:0]       code_q,     code_d;
    logic               err_q,      err_d;
    // Error counter
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    logic               in_xfer;
    logic               out_xfer;
    logic               s2_load;
    logic [N-1:0]       enc_code;
    logic [N:0]         enc_pop;
    logic               enc_err;

    // Encoder on the S1 word. Scanning from the top down lets the lowest set
    // bit overwrite any higher one, giving LSB priority; an all-zero word
    // leaves the code at 0. Popcount needs N+1 bits to hold W.
    always_comb begin
        enc_code = '0;
        enc_pop  = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (s1_lines_q[i]) begin
                enc_code = N'(i);
            end
        end
        for (int i = 0; i < W; i++) begin
            enc_pop = enc_pop + (N+1)'(s1_lines_q[i]);
        end
        enc_err = (enc_pop != (N+1)'(1));
    end

    // Handshake. in_ready depends only on state and out_ready, never on
    // in_valid, so no combinational loop can form through a producer.
    always_comb begin
        in_ready = !s1_v_q || !s2_v_q || out_ready;
        in_xfer  = in_valid && in_ready;
        out_xfer = s2_v_q && out_ready;
        s2_load  = s1_v_q && (!s2_v_q || out_ready);
    end

    // Next state. A stage that hands its word on without receiving a new one
    // drops its valid; data registers otherwise hold so the outputs stay
    // deterministic while out_valid is low.
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_lines_d = s1_lines_q;
        s2_v_d     = s2_v_q;
        code_d     = code_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        if (in_xfer) begin
            s1_v_d     = 1'b1;
            s1_lines_d = in_lines;
        end else if (s2_load) begin
            s1_v_d     = 1'b0;
        end

        if (s2_load) begin
            s2_v_d = 1'b1;
            code_d = enc_code;
            err_d  = enc_err;
        end else if (out_xfer) begin
            s2_v_d = 1'b0;
        end

        // Counts the departing result, even when S2 reloads in the same cycle.
        if (out_xfer && err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_lines_q <= '0;
            s2_v_q     <= 1'b0;
            code_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_lines_q <= s1_lines_d;
            s2_v_q     <= s2_v_d;
            code_q     <= code_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_code  = code_q;
    assign out_err   = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_onehot_encoder.sv
// Purpose : bench for onehot_encoder (N=2) with an 8-bit and a 2-bit error counter instance.
// Latency : reference results become visible one edge after the accepting edge.
// Backpr. : random and directed out_ready stalls; inputs may change while stalled.
module tb_onehot_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_lines;
    logic       out_ready;

    logic       in_ready,  s_in_ready;
    logic       out_valid, s_out_valid;
    logic [1:0] out_code,  s_out_code;
    logic       out_err,   s_out_err;
    logic [7:0] err_cnt;
    logic [1:0] s_err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    onehot_encoder #(.N(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_lines(in_lines),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_err(out_err), .err_cnt(err_cnt)
    );

    onehot_encoder #(.N(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_lines(in_lines),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_code(s_out_code), .out_err(s_out_err), .err_cnt(s_err_cnt)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0] code;
        logic       err;
        int         acc;   // edge number at which the word was accepted
    } exp_t;

    exp_t q[$];
    int   edge_no = 0;     // edges seen so far, as of the current low phase
    int   m_err   = 0;     // unsaturated count of departed error results

    function automatic logic [1:0] ref_code(logic [3:0] l);
        for (int i = 0; i < 4; i++) begin
            if (l[i]) return i[1:0];
        end
        return 2'd0;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge rst_n) begin
        q.delete();
        m_err = 0;
    end

    // Compare on every low phase; transfers computed here take effect at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_rdy, exp_vld;
            exp_t  ent;
            exp_rdy = (q.size() < 2) || out_ready;
            exp_vld = (q.size() > 0) && (q[0].acc < edge_no);
            chk("in_ready",    in_ready,    exp_rdy);
            chk("out_valid",   out_valid,   exp_vld);
            chk("s_in_ready",  s_in_ready,  exp_rdy);
            chk("s_out_valid", s_out_valid, exp_vld);
            if (exp_vld) begin
                chk("out_code",   out_code,   q[0].code);
                chk("out_err",    out_err,    q[0].err);
                chk("s_out_code", s_out_code, q[0].code);
            end
            chk("err_cnt",   err_cnt,   sat(m_err, 255));
            chk("s_err_cnt", s_err_cnt, sat(m_err, 3));
            if (exp_vld && out_ready) begin
                if (q[0].err) m_err++;
                void'(q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                ent.code = ref_code(in_lines);
                ent.err  = ($countones(in_lines) != 1);
                ent.acc  = edge_no + 1;
                q.push_back(ent);
            end
            edge_no++;
        end
    end

    // ---------------- directed stimulus ----------------
    logic [3:0] d_w[5];
    logic [1:0] d_c[5];
    logic       d_e[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams n words one per cycle with out_ready high and checks literal results.
    task automatic stream(int n, int base);
        int run;
        run = base;
        out_ready = 1'b1;
        for (int j = 0; j < n + 2; j++) begin
            if (j < n) begin
                in_valid = 1'b1;
                in_lines = d_w[j];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j < 2) begin
                chk("d_lat_vld", out_valid, 1'b0);
            end else begin
                chk("d_vld",     out_valid, 1'b1);
                chk("d_code",    out_code,  d_c[j-2]);
                chk("d_err",     out_err,   d_e[j-2]);
                chk("d_cnt",     err_cnt,   run);
                chk("d_sat_cnt", s_err_cnt, sat(run, 3));
                if (d_e[j-2]) run++;
            end
            step();
        end
        @(negedge clk);
        chk("d_end_vld",     out_valid, 1'b0);
        chk("d_end_cnt",     err_cnt,   run);
        chk("d_end_sat_cnt", s_err_cnt, sat(run, 3));
        step();
    endtask

    logic [3:0] bp_w[4];
    logic [1:0] got[8];
    int         ng, idx, acc_n;
    logic       acc_now;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_lines  = 4'b0000;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_code",  out_code,  2'd0);
        chk("rst_err_cnt",   err_cnt,   8'd0);
        step();
        step();
        rst_n = 1'b1;

        // Truth table
        d_w = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        d_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        d_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        stream(4, 0);

        // Error words: codes 0,1,0, all flagged; counter reaches 3
        d_w = '{4'b0000, 4'b0110, 4'b1111, 4'b0000, 4'b0000};
        d_c = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        d_e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        stream(3, 0);

        // Backpressure: 4 words offered, consumer stalled for the first 6 cycles
        bp_w = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        idx = 0; ng = 0; acc_n = 0;
        in_valid  = 1'b1;
        in_lines  = bp_w[0];
        out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c == 6) out_ready = 1'b1;
            @(negedge clk);
            if (c >= 2 && c < 6) begin
                chk("bp_in_ready", in_ready,  1'b0);
                chk("bp_vld",      out_valid, 1'b1);
                chk("bp_code",     out_code,  2'd0);
            end
            if (c == 6) begin
                chk("bp_absorbed", acc_n,    2);
                chk("bp_resume",   in_ready, 1'b1);
            end
            acc_now = in_valid && in_ready;
            if (acc_now) acc_n++;
            if (out_valid && out_ready && ng < 8) begin
                got[ng] = out_code;
                ng++;
            end
            step();
            if (acc_now) begin
                idx++;
                if (idx < 4) in_lines = bp_w[idx];
                else         in_valid = 1'b0;
            end
        end
        chk("bp_count", ng, 4);
        for (int k = 0; k < 4; k++) begin
            chk("bp_order", got[k], k);
        end

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_lines  = 4'b1000;
        step();
        in_lines  = 4'b0001;
        step();
        in_valid  = 1'b0;
        @(negedge clk);
        chk("mid_full_rdy", in_ready,  1'b0);
        chk("mid_full_vld", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 1'b0);
        chk("mid_rst_cnt", err_cnt,   8'd0);
        chk("mid_rst_rdy", in_ready,  1'b1);
        step();
        step();
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_lines  = 4'b0100;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_lat1", out_valid, 1'b0);
        step();
        @(negedge clk);
        chk("post_rst_vld",  out_valid, 1'b1);
        chk("post_rst_code", out_code,  2'd2);
        step();
        step();

        // Saturation of the 2-bit counter: 1,2,3,3,3
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        d_w = '{4'b0000, 4'b0011, 4'b1010, 4'b1111, 4'b1100};
        d_c = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
        d_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        stream(5, 0);
        chk("sat_final", s_err_cnt, 2'd3);

        // Random traffic, checked by the model every cycle
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_lines  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
